prbs_xnor_checker: RTL

Serial PRBS checker that sits directly downstream of the XNOR gate stage. It regenerates the expected pseudo-random sequence with an XNOR-feedback LFSR and synchronises to the received bit stream. Each received bit is compared against the prediction (match = XNOR of received and expected). The block counts bit errors and reports lock and loss-of-sync, for link and loopback self-test on the FPGA.

---
 rtl/prbs_pkg.sv | 17 +
 rtl/prbs_xnor_checker_if.sv | 22 ++
 rtl/xnor_lfsr.sv | 38 +++
 rtl/prbs_xnor_checker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR PRBS checker: state encoding, PRBS7 defaults
// and the lock-up value of an XNOR-feedback LFSR.
package prbs_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SEED   = 2'd0;
  localparam state_t VERIFY = 2'd1;
  localparam state_t LOCKED = 2'd2;

  localparam int PRBS7_WIDTH = 7;
  localparam int PRBS7_TAP   = 6;

  // An XNOR LFSR with every bit equal to this value never leaves that state.
  localparam logic LOCKUP_BIT = 1'b1;

endpackage

// File: rtl/prbs_xnor_checker_if.sv
// Serial receive and status bundle between the link and the PRBS checker.
interface prbs_xnor_checker_if #(
  parameter int ERR_W = 16
);
  logic             en;
  logic             rx_bit;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic             sync_lost;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, rx_bit, clear,
    input  locked, err_pulse, sync_lost, err_cnt
  );

  modport slave (
    input  en, rx_bit, clear,
    output locked, err_pulse, sync_lost, err_cnt
  );
endinterface

// File: rtl/xnor_lfsr.sv
// XNOR-feedback Fibonacci LFSR with a predicted-bit output; either free-runs on
// its own feedback or shifts in an external bit. Used as checker and generator.
module xnor_lfsr
  import prbs_pkg::*;
#(
  parameter int WIDTH = PRBS7_WIDTH,
  parameter int TAP   = PRBS7_TAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_sel_i,
  input  logic             load_bit_i,
  output logic             pred_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign pred_o = ~(q_q[WIDTH-1] ^ q_q[TAP-1]);

  // Word the next enabled edge will load, whichever source is selected.
  assign next_o = {q_q[WIDTH-2:0], (load_sel_i ? load_bit_i : pred_o)};

  // NOTE: next-state logic gives every output a default first, so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (en_i) q_d = next_o;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/prbs_xnor_checker.sv
// Serial PRBS checker: seeds an XNOR LFSR from the received stream, verifies it,
// then counts bit errors while locked and drops lock on a burst of errors.
module prbs_xnor_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH      = PRBS7_WIDTH,
  parameter int TAP        = PRBS7_TAP,
  parameter int LOCK_CNT   = 16,
  parameter int WIN_BITS   = 64,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  prbs_xnor_checker_if.slave  bus
);

  localparam int SEED_W = (WIDTH      > 1) ? $clog2(WIDTH)      : 1;
  localparam int RUN_W  = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
  localparam int WIN_W  = (WIN_BITS   > 1) ? $clog2(WIN_BITS)   : 1;
  localparam int WERR_W = (UNLOCK_ERR > 1) ? $clog2(UNLOCK_ERR) : 1;

  localparam logic [WIDTH-1:0] LOCKUP  = {WIDTH{LOCKUP_BIT}};
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t              state_q,    state_d;
  logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
  logic [RUN_W-1:0]    run_cnt_q,  run_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q,  win_cnt_d;
  logic [WERR_W-1:0]   win_err_q,  win_err_d;
  logic [ERR_W-1:0]    err_cnt_q,  err_cnt_d;
  logic                locked_q,    err_pulse_q, sync_lost_q;

  logic                lfsr_pred;
  logic [WIDTH-1:0]    lfsr_next;
  logic                match;
  logic                err_hit;
  logic                unlock;

  xnor_lfsr #(
    .WIDTH (WIDTH),
    .TAP   (TAP)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (bus.en),
    .load_sel_i (state_q == SEED),
    .load_bit_i (bus.rx_bit),
    .pred_o     (lfsr_pred),
    .next_o     (lfsr_next)
  );

  assign match = ~(bus.rx_bit ^ lfsr_pred);

  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q;
    run_cnt_d  = run_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    err_hit    = 1'b0;
    unlock     = 1'b0;
    if (bus.en) begin
      case (state_q)
        SEED: begin
          // Seeding into the lock-up word would leave the LFSR stuck; start over.
          if (lfsr_next == LOCKUP) begin
            seed_cnt_d = '0;
          end else if (seed_cnt_q == SEED_W'(WIDTH - 1)) begin
            seed_cnt_d = '0;
            run_cnt_d  = '0;
            state_d    = VERIFY;
          end else begin
            seed_cnt_d = seed_cnt_q + SEED_W'(1);
          end
        end
        VERIFY: begin
          if (!match) begin
            run_cnt_d  = '0;
            seed_cnt_d = '0;
            state_d    = SEED;
          end else if (run_cnt_q == RUN_W'(LOCK_CNT - 1)) begin
            run_cnt_d = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            state_d   = LOCKED;
          end else begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end
        end
        LOCKED: begin
          err_hit = ~match;
          if (err_hit && (win_err_q == WERR_W'(UNLOCK_ERR - 1))) begin
            unlock     = 1'b1;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
            state_d    = SEED;
          end else if (win_cnt_q == WIN_W'(WIN_BITS - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_q + WERR_W'(err_hit);
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  // A clear landing on an error cycle keeps that error in the fresh count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clear)                           err_cnt_d = ERR_W'(err_hit);
    else if (err_hit && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      seed_cnt_q  <= '0;
      run_cnt_q   <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      run_cnt_q   <= run_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_hit;
      sync_lost_q <= unlock;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.sync_lost = sync_lost_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
